// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter that serialises transactions onto a
// single fixed-latency memory port and returns a one-cycle response.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic                  req0_we,
  input  logic                  req1_we,
  input  logic [DATA_WIDTH-1:0] req0_wd,
  input  logic [DATA_WIDTH-1:0] req1_wd,
  input  logic [2:0]            req0_mode,
  input  logic [2:0]            req1_mode,
  output logic [1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic [2:0]            mem_mode,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic [31:0]           grant_cnt0,
  output logic [31:0]           grant_cnt1,
  output logic [31:0]           stall_cnt0,
  output logic [31:0]           stall_cnt1
);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be >= 1");
  end

  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LATENCY - 1);
  localparam logic [31:0]   CNT_MAX  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  gnt_q, gnt_d;
  logic                  first_q, first_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [2:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [31:0]           gcnt_q [2];
  logic [31:0]           gcnt_d [2];
  logic [31:0]           scnt_q [2];
  logic [31:0]           scnt_d [2];
  logic                  win;

  // Handshake: a request transfers in the cycle where req_valid[i] and
  // req_ready[i] are both high; ready is only ever offered in IDLE.
  always_comb begin
    if (req_valid == 2'b01)      win = 1'b0;
    else if (req_valid == 2'b10) win = 1'b1;
    else                         win = ~last_grant_q;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    first_d      = first_q;
    lat_d        = lat_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wd_d         = wd_q;
    mode_d       = mode_q;
    rdata_d      = rdata_q;
    req_ready    = 2'b00;
    resp_valid   = 2'b00;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready[win] = 1'b1;
          addr_d         = win ? req1_addr : req0_addr;
          we_d           = win ? req1_we   : req0_we;
          wd_d           = win ? req1_wd   : req0_wd;
          mode_d         = win ? req1_mode : req0_mode;
          last_grant_d   = win;
          gnt_d          = win;
          lat_d          = LAT_LOAD;
          first_d        = 1'b1;
          state_d        = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_en  = 1'b1;
        // The write strobe is a single pulse even when the access lasts longer.
        mem_we  = we_q & first_q;
        first_d = 1'b0;
        if (lat_q != '0) begin
          lat_d = lat_q - LW'(1);
        end else begin
          rdata_d = we_q ? '0 : mem_rd;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid[gnt_q] = 1'b1;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      gcnt_d[i] = gcnt_q[i];
      scnt_d[i] = scnt_q[i];
      if (req_ready[i] && gcnt_q[i] != CNT_MAX) gcnt_d[i] = gcnt_q[i] + 32'd1;
      if (req_valid[i] && !req_ready[i] && scnt_q[i] != CNT_MAX) scnt_d[i] = scnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      first_q      <= 1'b0;
      lat_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wd_q         <= '0;
      mode_q       <= '0;
      rdata_q      <= '0;
      for (int i = 0; i < 2; i++) begin
        gcnt_q[i] <= '0;
        scnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      first_q      <= first_d;
      lat_q        <= lat_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wd_q         <= wd_d;
      mode_q       <= mode_d;
      rdata_q      <= rdata_d;
      for (int i = 0; i < 2; i++) begin
        gcnt_q[i] <= gcnt_d[i];
        scnt_q[i] <= scnt_d[i];
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wd     = wd_q;
  assign mem_mode   = mode_q;
  assign grant_cnt0 = gcnt_q[0];
  assign grant_cnt1 = gcnt_q[1];
  assign stall_cnt0 = scnt_q[0];
  assign stall_cnt1 = scnt_q[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: a transaction-level reference model
// predicts grants, memory command windows, counters and responses.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ML = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready, resp_valid;
  logic [AW-1:0] a [2] = '{32'h0, 32'h0};
  logic          w [2] = '{1'b0, 1'b0};
  logic [DW-1:0] d [2] = '{32'h0, 32'h0};
  logic [2:0]    m [2] = '{3'd0, 3'd0};
  logic [DW-1:0] resp_rdata, mem_wd, mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_en, mem_we;
  logic [2:0]    mem_mode;
  logic [31:0]   grant_cnt0, grant_cnt1, stall_cnt0, stall_cnt1;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(ML)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_addr(a[0]), .req1_addr(a[1]), .req0_we(w[0]), .req1_we(w[1]),
    .req0_wd(d[0]), .req1_wd(d[1]), .req0_mode(m[0]), .req1_mode(m[1]),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_mode(mem_mode), .mem_rd(mem_rd),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
    .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
  );

  // ---------------- memory contents ----------------
  function automatic logic [31:0] hash(input logic [31:0] addr);
    return 32'hDEAD_BEEF ^ ((addr - 32'h10) * 32'h9E37_79B9);
  endfunction

  logic [31:0] fm_d [256];
  bit          fm_v [256];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      fm_d[mem_addr[9:2]] <= mem_wd;
      fm_v[mem_addr[9:2]] <= 1'b1;
    end
  end
  assign mem_rd = !mem_en ? '0 :
                  (fm_v[mem_addr[9:2]] ? fm_d[mem_addr[9:2]] : hash(mem_addr));

  // ---------------- scoreboard bookkeeping ----------------
  typedef struct {
    int          who;
    logic [31:0] rdata;
    int unsigned due;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  bit          busy = 1'b0;
  int unsigned acc = 0;
  logic        acc_we = 1'b0;
  logic [31:0] acc_a = '0, acc_d = '0;
  logic [2:0]  acc_m = '0;
  int          last_g = 1;
  int unsigned gm [2] = '{0, 0};
  int unsigned sm [2] = '{0, 0};
  logic [31:0] rm_d [256];
  bit          rm_v [256];
  logic [1:0]  hs = 2'b00;

  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    bit         exp_en, exp_we;
    int         win;
    exp_t       e;
    hs = req_valid & req_ready;
    if (busy && cyc > acc + ML + 1) busy = 1'b0;
    exp_en = busy && cyc >= acc + 1 && cyc <= acc + ML;
    exp_we = busy && cyc == acc + 1 && acc_we;
    check("mem_en", mem_en, exp_en);
    if (rst) begin
      busy = 1'b0; last_g = 1;
      gm = '{0, 0}; sm = '{0, 0};
      exp_q.delete();
    end else begin
      exp_rdy = 2'b00;
      win = 0;
      if (!busy && req_valid != 2'b00) begin
        win = (req_valid == 2'b11) ? 1 - last_g : (req_valid[1] ? 1 : 0);
        exp_rdy[win] = 1'b1;
      end
      check("req_ready", req_ready, exp_rdy);
      check("mem_we", mem_we, exp_we);
      if (exp_en) begin
        check("mem_addr", mem_addr, acc_a);
        check("mem_wd", mem_wd, acc_d);
        check("mem_mode", mem_mode, acc_m);
      end
      check("grant_cnt0", grant_cnt0, gm[0]);
      check("grant_cnt1", grant_cnt1, gm[1]);
      check("stall_cnt0", stall_cnt0, sm[0]);
      check("stall_cnt1", stall_cnt1, sm[1]);
      for (int i = 0; i < 2; i++)
        if (req_valid[i] && !exp_rdy[i] && sm[i] != 32'hFFFF_FFFF) sm[i]++;
      if (exp_rdy != 2'b00) begin
        if (gm[win] != 32'hFFFF_FFFF) gm[win]++;
        last_g = win; busy = 1'b1; acc = cyc;
        acc_a = a[win]; acc_we = w[win]; acc_d = d[win]; acc_m = m[win];
        e.who = win;
        e.due = cyc + ML + 1;
        e.rdata = acc_we ? 32'h0 : (rm_v[acc_a[9:2]] ? rm_d[acc_a[9:2]] : hash(acc_a));
        if (acc_we) begin
          rm_v[acc_a[9:2]] = 1'b1;
          rm_d[acc_a[9:2]] = acc_d;
        end
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (resp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", resp_valid, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check("resp_valid", resp_valid, 64'd1 << e.who);
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_cycle", cyc, e.due);
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        e = exp_q.pop_front();
        check("resp_missing", cyc, e.due);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic new_payload(input int i);
    a[i] = {22'b0, 8'($urandom), 2'b00};
    w[i] = ($urandom_range(0, 2) == 0);
    d[i] = $urandom;
    m[i] = 3'($urandom_range(0, 4));
  endtask

  task automatic issue(input int i, input logic [31:0] addr, input logic we_i,
                       input logic [31:0] wd_i, input logic [2:0] md);
    int n = 0;
    @(posedge clk); #1;
    a[i] = addr; w[i] = we_i; d[i] = wd_i; m[i] = md;
    req_valid[i] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 100);
    check("issue_accept", req_ready[i], 1'b1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic random_phase(input int cycles, input int p_raise, input int p_drop);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && hs[i]) begin
          if ($urandom_range(0, 99) < p_raise) new_payload(i);
          else req_valid[i] = 1'b0;
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 99) < p_drop) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 99) < p_raise) begin
          new_payload(i);
          req_valid[i] = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  // ---------------- stimulus sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    check("rst_mem_mode", mem_mode, 3'd0);

    issue(0, 32'h10, 1'b0, 32'h0, 3'd2);
    repeat (6) @(posedge clk);

    #1;
    new_payload(0); new_payload(1);
    req_valid = 2'b11;
    random_phase(15, 100, 0);
    repeat (6) @(posedge clk);

    issue(1, 32'h40, 1'b1, 32'h0000_00AB, 3'd0);
    repeat (6) @(posedge clk);

    fork
      issue(0, 32'h44, 1'b0, 32'h0, 3'd2);
      begin
        @(posedge clk);
        issue(1, 32'h40, 1'b0, 32'h0, 3'd2);
      end
    join
    repeat (6) @(posedge clk);

    random_phase(3000, 30, 5);
    repeat (8) @(posedge clk);

    #1;
    a[0] = 32'h80; w[0] = 1'b0; d[0] = 32'h0; m[0] = 3'd2;
    req_valid[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_resp_rdata", resp_rdata, 32'h0);
    repeat (6) @(posedge clk);
    issue(1, 32'h84, 1'b0, 32'h0, 3'd2);
    repeat (8) @(posedge clk);

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single data memory port.
- Requester 0 is the instruction-side cache refill. Requester 1 is the data-side cache miss/store path.
- Serialises one transaction at a time into a fixed-latency memory, then returns a one-cycle response to the requester that was granted.
- Also keeps per-requester grant and stall counters for the performance-counter readout.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- MEM_LATENCY, 2, cycles from memory command to valid mem_rd. Must be >= 1; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  2  request pending, one bit per requester.
- req_ready  out  2  request accepted this cycle (combinational, at most one bit set).
- req0_addr / req1_addr  in  ADDR_WIDTH  request address.
- req0_we / req1_we  in  1  1 = store.
- req0_wd / req1_wd  in  DATA_WIDTH  store data.
- req0_mode / req1_mode  in  3  AddrMode (byte/half/word encoding), passed through to memory.
- resp_valid  out  2  response strobe, one cycle, one bit per requester.
- resp_rdata  out  DATA_WIDTH  load data; 0 for stores.
- mem_en  out  1  memory command active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  latched address.
- mem_wd  out  DATA_WIDTH  latched store data.
- mem_mode  out  3  latched AddrMode.
- mem_rd  in  DATA_WIDTH  memory read data.
- grant_cnt0 / grant_cnt1  out  32  accepted transactions per requester.
- stall_cnt0 / stall_cnt1  out  32  cycles with req_valid[i]=1 and req_ready[i]=0.

Behaviour:
- Reset values:
  - FSM state = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - All outputs and counters = 0; resp_rdata = 0; latched command registers = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req_valid is set, pick a winner. Single requester wins outright. If both are valid, the winner is the requester != last_grant.
  - req_ready[winner] = 1 in the same cycle.
  - At the clock edge: latch addr/we/wd/mode, set last_grant = winner, load lat_cnt = MEM_LATENCY-1, go to ACCESS.
  - If no request is valid, stay in IDLE.
- ACCESS:
  - mem_en = 1; mem_addr/mem_wd/mem_mode driven from the latched registers.
  - mem_we = latched we on the first ACCESS cycle only; 0 afterwards.
  - While lat_cnt != 0: decrement it. When lat_cnt == 0: capture mem_rd (or 0 if store) into resp_rdata and go to RESP.
- RESP:
  - resp_valid[granted] = 1 for exactly one cycle; resp_rdata holds until the next RESP.
  - Next state is IDLE. No new grant is given in the RESP cycle.
- Latency: if accepted in cycle T, ACCESS spans T+1 .. T+MEM_LATENCY and resp_valid is asserted in T+MEM_LATENCY+1. Throughput is one transaction per MEM_LATENCY+2 cycles.
- mem_en = 0 and mem_we = 0 in IDLE and RESP.
- Requester obligations: hold valid and payload stable until req_ready. Dropping valid before acceptance withdraws the request with no side effects.
- A request asserted while the arbiter is in ACCESS or RESP waits; stall_cnt increments every such cycle.
- Counters are saturating at 32'hFFFF_FFFF.
  - grant_cnt increments on acceptance.
  - stall_cnt increments in any cycle with valid high and ready low, including the losing requester in IDLE.
- Reset mid-transaction: the transaction is abandoned. No resp_valid is issued, mem_en drops on the next cycle, and the counters clear.
- Stores and loads share the same timing. AddrMode is not interpreted here; byte lanes are the memory's job.

Test Plan:
- Single load, MEM_LATENCY=2: req_valid=01, addr=0x10, mem_rd=0xDEADBEEF. Expect ready[0] at T, mem_en high at T+1..T+2, resp_valid=01 with rdata=0xDEADBEEF at T+3; grant_cnt0=1.
- Simultaneous requests from reset: req_valid=11 held. Expect grants in order 0,1,0,1 at cycles T, T+4, T+8, T+12; each resp goes to the matching bit. After 4 transactions: stall_cnt1 ≥ 4, grant_cnt0 = grant_cnt1 = 2.
- Store: req1_we=1, wd=0x000000AB, mode=byte. Expect mem_we high for exactly one cycle (T+1) with mem_wd=0xAB, resp_valid=10 at T+3 with rdata=0.
- Request arrives during ACCESS: req0 is accepted; req1 rises at T+1. Expect ready[1] no earlier than T+4, stall_cnt1=3 at acceptance.
- Reset mid-ACCESS: rst=1 at T+1. Expect no resp_valid afterwards, mem_en=0 at T+2, all counters 0. A following single req1 is granted normally.
- MEM_LATENCY=1 build: single load gives resp_valid at T+2; a back-to-back request is accepted at T+3.
